// File: rtl/exception_control_unit_pkg.sv
// Shared definitions for the exception control unit: state encoding and
// architectural constants also used by the decoder.
package exception_control_unit_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFlush    = 3'd1,
        StRedirect = 3'd2,
        StHandler  = 3'd3,
        StReturn   = 3'd4,
        StHalted   = 3'd5
    } ecu_state_e;

    localparam logic [31:0] HandlerAddrDefault = 32'h0000_0100;
    localparam logic [6:0]  NopOpcode          = 7'h00;
    localparam logic [6:0]  EretOpcode         = 7'h73;

endpackage

// File: rtl/exception_control_unit_flush_counter.sv
// Loadable 4-bit down-counter that times the front-end drain before redirect.
module exc_flush_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [3:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && count_q != 4'd0) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign zero = (count_q == 4'd0);
endmodule

// File: rtl/exception_control_unit.sv
// Exception sequencer: captures EPC/cause, drains the front end, redirects to the
// handler, returns to EPC+4 on eret, and halts on a fault inside the handler.
module exception_control_unit
    import exception_control_unit_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = HandlerAddrDefault,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 excep_flag,
    input  logic [31:0]          ID_PC,
    input  logic [6:0]           ID_opcode,
    input  logic                 eret,
    output logic [31:0]          EPC,
    output logic [6:0]           cause,
    output logic                 pc_redirect,
    output logic [31:0]          redirect_addr,
    output logic                 IF_FLUSH,
    output logic                 pipe_stall,
    output logic                 in_handler,
    output logic                 double_fault,
    output logic [CNT_WIDTH-1:0] excep_count
);
    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    ecu_state_e state_q, state_d;
    logic       accept;
    logic       flush_zero;

    assign accept = (state_q == StIdle) && excep_flag;

    exc_flush_counter u_flush_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (FlushLoad),
        .dec      (state_q == StFlush),
        .zero     (flush_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (excep_flag) state_d = StFlush;
            StFlush:    if (flush_zero) state_d = StRedirect;
            StRedirect: state_d = StHandler;
            // A fault inside the handler wins over a simultaneous eret.
            StHandler: begin
                if (excep_flag) begin
                    state_d = StHalted;
                end else if (eret) begin
                    state_d = StReturn;
                end
            end
            StReturn:   state_d = StIdle;
            StHalted:   state_d = StHalted;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            EPC         <= 32'd0;
            cause       <= NopOpcode;
            excep_count <= '0;
        end else if (accept) begin
            EPC   <= ID_PC;
            cause <= ID_opcode;
            if (excep_count != '1) begin
                excep_count <= excep_count + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        pc_redirect   = 1'b0;
        redirect_addr = 32'd0;
        IF_FLUSH      = 1'b0;
        pipe_stall    = 1'b0;
        in_handler    = 1'b0;
        double_fault  = 1'b0;
        unique case (state_q)
            StFlush: begin
                IF_FLUSH   = 1'b1;
                pipe_stall = 1'b1;
            end
            StRedirect: begin
                pc_redirect   = 1'b1;
                redirect_addr = HANDLER_ADDR;
                IF_FLUSH      = 1'b1;
            end
            StHandler: in_handler = 1'b1;
            StReturn: begin
                pc_redirect   = 1'b1;
                redirect_addr = EPC + 32'd4;
                IF_FLUSH      = 1'b1;
                in_handler    = 1'b1;
            end
            StHalted: begin
                IF_FLUSH     = 1'b1;
                pipe_stall   = 1'b1;
                double_fault = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/exception_control_unit.md
Name: exception_control_unit

Overview:
- Sits directly downstream of the decode-stage exception detector.
- Consumes its excep_flag together with the ID-stage PC and opcode.
- Captures EPC and cause, drains the front end, redirects fetch to a fixed handler vector, and returns to EPC+4 on eret.
- Handles a second exception raised while inside the handler as a double fault, which halts the core until reset.

Parameters:
- HANDLER_ADDR, 32'h0000_0100, fetch address of the exception handler.
- FLUSH_CYCLES, 2, number of cycles IF_FLUSH and pipe_stall are held before redirect; legal range 1..15.
- CNT_WIDTH, 8, width of the saturating exception counter.

Ports:
- clk  in  1  core clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- excep_flag  in  1  exception request from the detector; level signal, updated on negedge.
- ID_PC  in  32  PC of the instruction currently in ID.
- ID_opcode  in  7  opcode of the instruction currently in ID.
- eret  in  1  decode of a return-from-exception instruction in ID.
- EPC  out  32  captured PC of the faulting instruction.
- cause  out  7  captured opcode of the faulting instruction.
- pc_redirect  out  1  one-cycle pulse; fetch loads redirect_addr.
- redirect_addr  out  32  target address while pc_redirect=1; otherwise 0.
- IF_FLUSH  out  1  squashes the IF/ID register (inserts opcode 7'h00 nop).
- pipe_stall  out  1  freezes PC and IF/ID.
- in_handler  out  1  high while executing handler code.
- double_fault  out  1  sticky; high in HALTED.
- excep_count  out  CNT_WIDTH  number of accepted exceptions, saturating.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0, including EPC, cause and excep_count; the flush counter is cleared. A reset mid-flush or mid-handler abandons the sequence with no residual pulse.
- Sampling: excep_flag, ID_PC, ID_opcode and eret are sampled on posedge. excep_flag changes on negedge, so it is stable at every posedge.
- State IDLE:
  - excep_flag=1 -> EPC<=ID_PC, cause<=ID_opcode, excep_count<=count+1 (holds at all-ones), flush counter<=FLUSH_CYCLES-1, next state FLUSH.
  - eret is ignored in IDLE.
- State FLUSH:
  - IF_FLUSH=1 and pipe_stall=1.
  - The counter decrements each cycle; when it is 0, go to REDIRECT.
  - excep_flag is ignored here (it is the same fault still visible in ID).
  - Latency: FLUSH lasts exactly FLUSH_CYCLES cycles.
- State REDIRECT (1 cycle):
  - pc_redirect=1, redirect_addr=HANDLER_ADDR, IF_FLUSH=1, pipe_stall=0.
  - Next state HANDLER.
  - From excep_flag sampled high to pc_redirect high is FLUSH_CYCLES+1 posedges.
- State HANDLER:
  - in_handler=1.
  - excep_flag=1 -> double_fault<=1, next state HALTED; this takes priority over a simultaneous eret.
  - Otherwise eret=1 -> next state RETURN.
- State RETURN (1 cycle):
  - pc_redirect=1, redirect_addr=EPC+4 (modulo 2^32; 32'hFFFF_FFFC returns to 0), IF_FLUSH=1.
  - in_handler=0 on the next cycle; next state IDLE.
  - EPC and cause keep their values until the next accepted exception.
- State HALTED:
  - pipe_stall=1, IF_FLUSH=1 and double_fault=1, held permanently.
  - All inputs are ignored; only rst exits.
  - excep_count does not increment on a double fault.
- Outputs are Moore-decoded from state: pc_redirect, IF_FLUSH, pipe_stall, in_handler and redirect_addr are functions of state plus registers only.
- EPC, cause and excep_count are registers.
- No combinational path from any input to any output.

Decomposition:
- Shared package (team defines include) holds:
  - state encodings: IDLE=0, FLUSH=1, REDIRECT=2, HANDLER=3, RETURN=4, HALTED=5, 3 bits;
  - HANDLER_ADDR default;
  - nop opcode 7'h00;
  - the eret opcode constant, also used by the decoder.
- One natural sub-module: exc_flush_counter, a 4-bit loadable down-counter with a zero flag used by FLUSH. Everything else stays in the top module.

Test Plan:
- Basic exception: reset, then excep_flag=1 with ID_PC=32'h40, ID_opcode=7'h7A.
  - Required: EPC=32'h40, cause=7'h7A, excep_count=1.
  - IF_FLUSH/pipe_stall high for 2 cycles, then pc_redirect pulse with redirect_addr=32'h100, then in_handler=1.
- Return: in HANDLER, assert eret for 1 cycle.
  - Required: next cycle pc_redirect=1, redirect_addr=32'h44.
  - Then IDLE with in_handler=0; EPC still 32'h40.
- Double fault: in HANDLER, assert excep_flag and eret in the same cycle.
  - Required: HALTED, double_fault=1, pipe_stall=1 held.
  - excep_count unchanged; no pc_redirect for 20 cycles.
  - rst clears all outputs.
- Persistent flag: hold excep_flag high through FLUSH and REDIRECT.
  - Required: only one capture, excep_count=1; EPC is not overwritten.
- Boundaries:
  - ID_PC=32'hFFFF_FFFC exception then eret -> redirect_addr=32'h0.
  - 256 exceptions with CNT_WIDTH=8 -> excep_count saturates at 8'hFF.
- Async reset: assert rst mid-FLUSH, between clock edges.
  - Required: outputs drop to 0 immediately, not at the next posedge.
  - After release the state is IDLE and eret is ignored.
